gmii_rx_deframer: RTL and testbench
===================================

Name: gmii_rx_deframer

Overview:
- Receive-side stage directly downstream of the GMII interface slave side; consumes rxd/rxdv/rxer in the GMII clock domain.
- Strips preamble/SFD, delays the byte stream by 4 bytes to strip the FCS, checks CRC-32, enforces length limits.
- Emits a byte stream with last/error markers to the Ethernet RX parser.
- No backpressure: GMII cannot stall, so the consumer must accept every valid byte.

Parameters:
- MIN_LEN, 64: minimum frame length in bytes, SFD excluded, FCS included.
- MAX_LEN, 1518: maximum frame length in bytes, FCS included.
- PRE_MIN, 1: minimum count of 0x55 bytes required before SFD 0xD5.

Ports:
- clk  in  1  GMII RX clock, 125 MHz.
- arst  in  1  asynchronous reset, active-high.
- rxd  in  8  GMII receive data.
- rxdv  in  1  GMII receive data valid.
- rxer  in  1  GMII receive error.
- out_data  out  8  frame byte, FCS stripped.
- out_valid  out  1  out_data valid this cycle.
- out_last  out  1  final byte of the frame; qualified by out_valid.
- out_err  out  1  frame bad (CRC, rxer, runt, oversize); valid only with out_last.
- stat_good  out  1  one-cycle pulse per good frame.
- stat_bad  out  1  one-cycle pulse per bad or aborted frame, including frames too short to emit any byte.

Behaviour:
- Reset: all outputs 0; state IDLE; delay line empty; length counter 0; CRC register 0xFFFFFFFF; error flag cleared.
- All outputs are registered.
- IDLE, rxdv=1:
  - rxd=0x55: go to PREAMBLE, pre_cnt=1.
  - any other byte: go to DROP.
- PREAMBLE:
  - 0x55: pre_cnt++, saturating at 7.
  - 0xD5 with pre_cnt>=PRE_MIN: go to PAYLOAD, init CRC, clear length and delay line.
  - any other byte: go to DROP.
  - rxdv=0: go to IDLE, no stats.
- PAYLOAD, rxdv=1:
  - Byte is folded into CRC (reflected poly 0x04C11DB7, init 0xFFFFFFFF) and shifted into a 5-entry delay line; len++.
  - Once the delay line holds 5 entries, each new byte causes the oldest to be output the next cycle with out_valid=1, out_last=0.
  - Output latency is therefore 6 cycles from a byte's sampling.
- PAYLOAD, rxdv falls (first sample with rxdv=0):
  - Next cycle: if the delay line holds 5 entries, output the oldest with out_last=1.
  - The remaining 4 entries are the FCS and are discarded.
  - out_err = (crc != 0xDEBB20E3) | err_flag | (len<MIN_LEN).
  - Pulse stat_good or stat_bad in that same cycle; go to IDLE.
  - If fewer than 5 entries are held: no output, pulse stat_bad.
- rxer=1 in PAYLOAD: set err_flag and continue collecting.
- rxer=1 in IDLE/PREAMBLE: ignored; carrier extension is not supported.
- len reaches MAX_LEN+1:
  - Emit the oldest delay-line byte with out_last=1, out_err=1; pulse stat_bad.
  - Go to DROP; no further output.
- DROP: wait for rxdv=0, then go to IDLE; no stats issued from DROP except the oversize pulse above.
- Back-to-back frames with 1 idle cycle (IPG violation) must be handled: IDLE is re-entered in time to see the next 0x55.
- arst mid-frame: outputs drop to 0 asynchronously; no out_last and no stats for the partial frame. After release, a frame already in progress is ignored until rxdv goes low, because IDLE requires 0x55 at first rxdv.
- len counter is 11 bits and saturates.

Decomposition:
- Package eth_pkg:
  - state enum {IDLE, PREAMBLE, PAYLOAD, DROP}.
  - ETH_PRE=8'h55, ETH_SFD=8'hD5.
  - CRC32_POLY, CRC32_INIT, CRC32_RESIDUE=32'hDEBB20E3.
- Sub-module eth_crc32_byte: combinational 8-bit-per-step CRC-32 next-state function, reusable by the TX framer.

Test Plan:
- 7x0x55, 0xD5, 60-byte payload, correct FCS -> 60 out_valid bytes, last on byte 60, out_err=0, stat_good pulse; first byte 6 cycles after sampling.
- Same frame with one payload bit flipped -> 60 bytes, out_err=1 on last, stat_bad.
- Frame with rxer=1 on payload byte 10 and correct FCS -> out_err=1, stat_bad.
- 40-byte payload + FCS (runt, 44 bytes) -> 40 bytes out, out_err=1. 3-byte frame after SFD -> no output, stat_bad.
- 1600-byte frame -> output stops at 1514 bytes with last and err=1 in the same cycle, stat_bad; next frame after 1 idle cycle is received good.
- Preamble 0x55,0x57,...,0xD5 -> no output, no stats. Then assert arst during a valid frame's byte 30 -> outputs 0, no stats; the following frame is received good.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants, FSM state type and CRC-32 helpers.
// Used by the GMII RX deframer and reusable by the TX framer.
package eth_pkg;

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_e;

    localparam logic [7:0]  ETH_PRE       = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Ethernet shifts LSB first, so the register runs on the bit-reversed polynomial.
    localparam logic [31:0] CRC32_POLY_REFL = reflect32(CRC32_POLY);

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational CRC-32 next-state for one byte, LSB-first (Ethernet bit order).
// Zero latency; pure function of its inputs, no flow control.
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  dat_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    always_comb begin
        c = crc_i ^ {24'h0, dat_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/gmii_rx_deframer.sv
// GMII RX deframer: strips preamble/SFD and FCS, checks CRC-32 and length limits.
// Latency 6 cycles rxd->out_data; no backpressure, the consumer must take every byte.
module gmii_rx_deframer
    import eth_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int PRE_MIN = 1
) (
    input  logic       clk,
    input  logic       arst,
    input  logic [7:0] rxd,
    input  logic       rxdv,
    input  logic       rxer,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    output logic       out_err,
    output logic       stat_good,
    output logic       stat_bad
);

    localparam logic [10:0] LEN_OVF = 11'(MAX_LEN + 1);
    localparam logic [10:0] LEN_MIN = 11'(MIN_LEN);
    localparam logic [2:0]  PRE_REQ = 3'(PRE_MIN);

    logic [7:0]      rxd_q;
    logic            rxdv_q, rxer_q;
    state_e          state_q, state_d;
    logic [2:0]      pre_cnt_q, pre_cnt_d;
    logic [10:0]     len_q, len_d, len_inc;
    logic [31:0]     crc_q, crc_d, crc_nxt;
    logic            err_q, err_d;
    logic [4:0][7:0] dl_q, dl_d;
    logic [2:0]      dcnt_q, dcnt_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d, out_last_q, out_last_d, out_err_q, out_err_d;
    logic            stat_good_q, stat_good_d, stat_bad_q, stat_bad_d;
    logic            dl_full, ovf, frame_bad;

    eth_crc32_byte u_crc (
        .crc_i (crc_q),
        .dat_i (rxd_q),
        .crc_o (crc_nxt)
    );

    assign len_inc   = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
    assign dl_full   = (dcnt_q == 3'd5);
    assign ovf       = (len_inc == LEN_OVF);
    assign frame_bad = (crc_q != CRC32_RESIDUE) | err_q | (len_q < LEN_MIN);

    // Inputs are registered once so the FSM sees a clean GMII sample.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rxd_q   <= '0;
            rxdv_q  <= 1'b0;
            rxer_q  <= 1'b0;
            state_q <= IDLE;
        end else begin
            rxd_q   <= rxd;
            rxdv_q  <= rxdv;
            rxer_q  <= rxer;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (rxdv_q) state_d = (rxd_q == ETH_PRE) ? PREAMBLE : DROP;
            PREAMBLE: begin
                if (!rxdv_q)                                        state_d = IDLE;
                else if (rxd_q == ETH_SFD && pre_cnt_q >= PRE_REQ) state_d = PAYLOAD;
                else if (rxd_q != ETH_PRE)                          state_d = DROP;
            end
            PAYLOAD: begin
                if (!rxdv_q)  state_d = IDLE;
                else if (ovf) state_d = DROP;
            end
            DROP:    if (!rxdv_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pre_cnt_d   = pre_cnt_q;
        len_d       = len_q;
        crc_d       = crc_q;
        err_d       = err_q;
        dl_d        = dl_q;
        dcnt_d      = dcnt_q;
        out_data_d  = 8'h00;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_err_d   = 1'b0;
        stat_good_d = 1'b0;
        stat_bad_d  = 1'b0;
        case (state_q)
            IDLE: if (rxdv_q && rxd_q == ETH_PRE) pre_cnt_d = 3'd1;
            PREAMBLE: begin
                if (rxdv_q && rxd_q == ETH_PRE) begin
                    pre_cnt_d = (pre_cnt_q == 3'd7) ? 3'd7 : pre_cnt_q + 3'd1;
                end else if (rxdv_q && rxd_q == ETH_SFD && pre_cnt_q >= PRE_REQ) begin
                    crc_d  = CRC32_INIT;
                    len_d  = '0;
                    err_d  = 1'b0;
                    dl_d   = '0;
                    dcnt_d = '0;
                end
            end
            PAYLOAD: begin
                if (rxdv_q) begin
                    crc_d  = crc_nxt;
                    dl_d   = {dl_q[3:0], rxd_q};
                    dcnt_d = dl_full ? dcnt_q : dcnt_q + 3'd1;
                    len_d  = len_inc;
                    if (rxer_q) err_d = 1'b1;
                    out_valid_d = dl_full;
                    out_data_d  = dl_full ? dl_q[4] : 8'h00;
                    if (ovf) begin
                        out_last_d = 1'b1;
                        out_err_d  = 1'b1;
                        stat_bad_d = 1'b1;
                    end
                end else if (dl_full) begin
                    // The four youngest entries are the FCS and are never emitted.
                    out_valid_d = 1'b1;
                    out_data_d  = dl_q[4];
                    out_last_d  = 1'b1;
                    out_err_d   = frame_bad;
                    stat_good_d = !frame_bad;
                    stat_bad_d  = frame_bad;
                end else begin
                    stat_bad_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pre_cnt_q   <= '0;
            len_q       <= '0;
            crc_q       <= CRC32_INIT;
            err_q       <= 1'b0;
            dl_q        <= '0;
            dcnt_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
            stat_good_q <= 1'b0;
            stat_bad_q  <= 1'b0;
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            len_q       <= len_d;
            crc_q       <= crc_d;
            err_q       <= err_d;
            dl_q        <= dl_d;
            dcnt_q      <= dcnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
            stat_good_q <= stat_good_d;
            stat_bad_q  <= stat_bad_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_err   = out_err_q;
    assign stat_good = stat_good_q;
    assign stat_bad  = stat_bad_q;

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Bench for gmii_rx_deframer: frames built with a bit-serial CRC model, expected bytes and stats queued.
// Checks good, CRC-error, rxer, runt, oversize, bad-preamble, reset and back-to-back frames.
module tb_gmii_rx_deframer;

    logic       clk = 1'b0;
    logic       arst;
    logic [7:0] rxd;
    logic       rxdv, rxer;
    logic [7:0] out_data;
    logic       out_valid, out_last, out_err, stat_good, stat_bad;

    typedef struct packed {logic [7:0] data; logic last; logic err;} exp_t;

    exp_t       exp_q[$];
    bit         stat_q[$];
    logic [7:0] frm[$];
    exp_t       mon_e;
    bit         mon_g;
    int         total = 0, bad = 0, obs = 0, cyc = 0;
    int         lat_start = 0, lat_cyc = -1, cur_idx = -1;
    bit         lat_arm = 1'b0;

    gmii_rx_deframer dut (
        .clk       (clk),
        .arst      (arst),
        .rxd       (rxd),
        .rxdv      (rxdv),
        .rxer      (rxer),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_err   (out_err),
        .stat_good (stat_good),
        .stat_bad  (stat_bad)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            obs++;
            total++;
            if (lat_arm) begin
                lat_cyc = cyc;
                lat_arm = 1'b0;
            end
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL out_byte: got data=%h last=%b, required no output", out_data, out_last);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_data !== mon_e.data || out_last !== mon_e.last ||
                    (mon_e.last && out_err !== mon_e.err)) begin
                    bad++;
                    $display("FAIL out_byte: got data=%h last=%b err=%b, required data=%h last=%b err=%b",
                             out_data, out_last, out_err, mon_e.data, mon_e.last, mon_e.err);
                end
            end
        end
        if (stat_good === 1'b1 || stat_bad === 1'b1) begin
            obs++;
            total++;
            if (stat_q.size() == 0) begin
                bad++;
                $display("FAIL stat: got good=%b bad=%b, required no pulse", stat_good, stat_bad);
            end else begin
                mon_g = stat_q.pop_front();
                if (stat_good !== mon_g || stat_bad !== !mon_g) begin
                    bad++;
                    $display("FAIL stat: got good=%b bad=%b, required good=%b bad=%b",
                             stat_good, stat_bad, mon_g, !mon_g);
                end
            end
        end
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic build_frame(input int plen, input int flip);
        logic [31:0] c, fcs;
        logic [7:0]  b;
        frm.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < plen; i++) begin
            b = 8'(i * 37 + 5);
            frm.push_back(b);
            c = crc_upd(c, b);
        end
        fcs = ~c;
        for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
        if (flip >= 0) frm[flip] = frm[flip] ^ 8'h10;
    endtask

    task automatic expect_frame(input bit err);
        int n;
        n = frm.size();
        if (n >= 5) begin
            for (int i = 0; i <= n - 5; i++) exp_q.push_back('{frm[i], i == n - 5, err});
        end
        stat_q.push_back(n >= 5 && !err);
    endtask

    task automatic drive_frame(input int npre, input int rxer_idx, input bit arm_lat, input bit bad_pre);
        for (int i = 0; i < npre; i++) begin
            @(posedge clk); #1;
            rxdv = 1'b1; rxer = 1'b0;
            rxd  = (bad_pre && i == 1) ? 8'h57 : 8'h55;
        end
        @(posedge clk); #1;
        rxd = 8'hD5;
        for (int i = 0; i < frm.size(); i++) begin
            @(posedge clk); #1;
            rxd     = frm[i];
            rxer    = (i == rxer_idx);
            cur_idx = i;
            if (i == 0 && arm_lat) begin
                lat_start = cyc;
                lat_arm   = 1'b1;
            end
        end
        @(posedge clk); #1;
        rxdv = 1'b0; rxd = 8'h00; rxer = 1'b0; cur_idx = -1;
    endtask

    task automatic settle();
        repeat (12) @(posedge clk);
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        arst = 1'b1; rxdv = 1'b1; rxd = 8'h55; rxer = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h required 00", out_data); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b required 0", out_last); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b required 0", out_err); end
        total++; if (stat_good !== 1'b0) begin bad++; $display("FAIL reset_good: got %b required 0", stat_good); end
        total++; if (stat_bad !== 1'b0) begin bad++; $display("FAIL reset_bad: got %b required 0", stat_bad); end
        rxdv = 1'b0; rxer = 1'b0; rxd = 8'h00;
        #1 arst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if ({out_valid, stat_good, stat_bad} !== 3'b000) begin
            bad++; $display("FAIL post_reset_idle: got %b required 000", {out_valid, stat_good, stat_bad});
        end
    endtask

    task automatic test_good();
        build_frame(60, -1);
        expect_frame(1'b0);
        drive_frame(7, -1, 1'b1, 1'b0);
        settle();
        total++; if (lat_cyc !== lat_start + 7) begin
            bad++; $display("FAIL latency: first byte at cycle %0d, required %0d", lat_cyc, lat_start + 7);
        end
        total++; if (exp_q.size() + stat_q.size() !== 0) begin
            bad++; $display("FAIL good_drain: pending=%0d required=0", exp_q.size() + stat_q.size());
            exp_q.delete(); stat_q.delete();
        end
    endtask

    task automatic test_crc_err();
        build_frame(60, 17);
        expect_frame(1'b1);
        drive_frame(7, -1, 1'b0, 1'b0);
        settle();
        total++; if (exp_q.size() + stat_q.size() !== 0) begin
            bad++; $display("FAIL crc_drain: pending=%0d required=0", exp_q.size() + stat_q.size());
            exp_q.delete(); stat_q.delete();
        end
    endtask

    task automatic test_rxer();
        build_frame(60, -1);
        expect_frame(1'b1);
        drive_frame(7, 10, 1'b0, 1'b0);
        settle();
        total++; if (exp_q.size() + stat_q.size() !== 0) begin
            bad++; $display("FAIL rxer_drain: pending=%0d required=0", exp_q.size() + stat_q.size());
            exp_q.delete(); stat_q.delete();
        end
    endtask

    task automatic test_runt();
        int obs0;
        build_frame(40, -1);
        expect_frame(1'b1);
        drive_frame(7, -1, 1'b0, 1'b0);
        settle();
        total++; if (exp_q.size() + stat_q.size() !== 0) begin
            bad++; $display("FAIL runt_drain: pending=%0d required=0", exp_q.size() + stat_q.size());
            exp_q.delete(); stat_q.delete();
        end
        build_frame(0, -1);
        void'(frm.pop_back());
        expect_frame(1'b1);
        obs0 = obs;
        drive_frame(7, -1, 1'b0, 1'b0);
        settle();
        total++; if (obs - obs0 !== 1 || stat_q.size() !== 0) begin
            bad++; $display("FAIL tiny_frame: events=%0d pending=%0d, required events=1 pending=0",
                            obs - obs0, stat_q.size());
            exp_q.delete(); stat_q.delete();
        end
    endtask

    task automatic test_oversize();
        build_frame(1596, -1);
        for (int i = 0; i < 1514; i++) exp_q.push_back('{frm[i], i == 1513, 1'b1});
        stat_q.push_back(1'b0);
        drive_frame(7, -1, 1'b0, 1'b0);
        build_frame(60, -1);
        expect_frame(1'b0);
        drive_frame(7, -1, 1'b0, 1'b0);
        settle();
        total++; if (exp_q.size() + stat_q.size() !== 0) begin
            bad++; $display("FAIL oversize_drain: pending=%0d required=0", exp_q.size() + stat_q.size());
            exp_q.delete(); stat_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        build_frame(60, -1);
        expect_frame(1'b0);
        drive_frame(3, -1, 1'b0, 1'b0);
        build_frame(100, -1);
        expect_frame(1'b0);
        drive_frame(1, -1, 1'b0, 1'b0);
        settle();
        total++; if (exp_q.size() + stat_q.size() !== 0) begin
            bad++; $display("FAIL b2b_drain: pending=%0d required=0", exp_q.size() + stat_q.size());
            exp_q.delete(); stat_q.delete();
        end
    endtask

    task automatic test_bad_preamble();
        int obs0;
        obs0 = obs;
        build_frame(60, -1);
        drive_frame(7, -1, 1'b0, 1'b1);
        settle();
        total++; if (obs - obs0 !== 0) begin
            bad++; $display("FAIL bad_preamble: events=%0d required=0", obs - obs0);
        end
    endtask

    task automatic test_arst_midframe();
        build_frame(60, -1);
        for (int i = 0; i < 24; i++) exp_q.push_back('{frm[i], 1'b0, 1'b0});
        fork
            drive_frame(7, -1, 1'b0, 1'b0);
            begin
                wait (cur_idx == 30);
                @(negedge clk); #1;
                arst = 1'b1;
                #1;
                total++; if ({out_data, out_valid, out_last, out_err, stat_good, stat_bad} !== 13'h0) begin
                    bad++; $display("FAIL arst_outputs: got %h required 0",
                                    {out_data, out_valid, out_last, out_err, stat_good, stat_bad});
                end
                @(posedge clk);
                @(posedge clk);
                #2 arst = 1'b0;
            end
        join
        total++; if (exp_q.size() !== 0) begin
            bad++; $display("FAIL arst_partial: pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        build_frame(60, -1);
        expect_frame(1'b0);
        drive_frame(7, -1, 1'b0, 1'b0);
        settle();
        total++; if (exp_q.size() + stat_q.size() !== 0) begin
            bad++; $display("FAIL arst_next_frame: pending=%0d required=0", exp_q.size() + stat_q.size());
            exp_q.delete(); stat_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_crc_err();
        test_rxer();
        test_runt();
        test_oversize();
        test_back_to_back();
        test_bad_preamble();
        test_arst_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
